// File: rtl/noc_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : noc_tx_pkg
//  Brief    : Shared types and default sizes for the NoC transmit arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package noc_tx_pkg;

    localparam int c_DEF_DATA_W        = 32;
    localparam int c_DEF_NUM_REQ       = 4;
    localparam int c_DEF_MAX_PKT_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/noc_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : noc_tx_arbiter_if
//  Brief    : Requester-side and NoC-side handshake bundle of the TX arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface noc_tx_arbiter_if
    import noc_tx_pkg::*;
#(
    parameter int NUM_REQ = c_DEF_NUM_REQ,
    parameter int DATA_W  = c_DEF_DATA_W,
    localparam int ID_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         noc_data;
    logic                      noc_valid;
    logic                      noc_ready;
    logic                      noc_last;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;
    logic                      pkt_err;

    modport master (
        output req_valid, req_data, req_last, noc_ready,
        input  req_ready, noc_data, noc_valid, noc_last, grant_id, busy, pkt_err
    );

    modport slave (
        input  req_valid, req_data, req_last, noc_ready,
        output req_ready, noc_data, noc_valid, noc_last, grant_id, busy, pkt_err
    );
endinterface
`default_nettype wire

// File: rtl/noc_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational round-robin winner search starting after last_grant.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import noc_tx_pkg::*;
#(
    parameter int NUM_REQ = c_DEF_NUM_REQ,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    // Walk offsets from farthest to nearest so the closest set index wins.
    always_comb begin
        winner  = '0;
        any_req = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[ID_W'((int'(last_grant) + k) % NUM_REQ)]) begin
                winner = ID_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : noc_tx_arbiter
//  Brief    : Packet-granular round-robin arbiter feeding a registered NoC stage.
//             Define NOC_TX_ARB_PRIO_EN to give requester 0 strict priority.
//  Revision : 1.0 - initial release
// ============================================================================
module noc_tx_arbiter
    import noc_tx_pkg::*;
#(
    parameter int NUM_REQ       = c_DEF_NUM_REQ,
    parameter int DATA_W        = c_DEF_DATA_W,
    parameter int MAX_PKT_WORDS = c_DEF_MAX_PKT_WORDS
) (
    input  logic            clk,
    input  logic            reset_n,
    noc_tx_arbiter_if.slave bus
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int c_LEN_W = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [c_LEN_W-1:0] c_LEN_LAST  = c_LEN_W'(MAX_PKT_WORDS - 1);
    localparam logic [ID_W-1:0]    c_LAST_INIT = ID_W'(NUM_REQ - 1);

    state_t              r_state;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_grant_id;
    logic [c_LEN_W-1:0]  r_pkt_len;
    logic                r_busy;
    logic                r_pkt_err;
    logic [DATA_W-1:0]   r_noc_data;
    logic                r_noc_valid;
    logic                r_noc_last;

    logic [DATA_W-1:0]   w_req_word [NUM_REQ];
    logic [NUM_REQ-1:0]  w_pick_req;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic [ID_W-1:0]     w_rr_winner;
    logic [ID_W-1:0]     w_winner;
    logic                w_rr_any;
    logic                w_any;
    logic                w_accept;
    logic                w_own_last;
    logic                w_pkt_end;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_word[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

`ifdef NOC_TX_ARB_PRIO_EN
    // Requester 0 bypasses the rotation; the rest rotate among themselves.
    assign w_pick_req = {bus.req_valid[NUM_REQ-1:1], 1'b0};
    assign w_any      = w_rr_any | bus.req_valid[0];
    assign w_winner   = bus.req_valid[0] ? '0 : w_rr_winner;
`else
    assign w_pick_req = bus.req_valid;
    assign w_any      = w_rr_any;
    assign w_winner   = w_rr_winner;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req        (w_pick_req),
        .last_grant (r_last_grant),
        .winner     (w_rr_winner),
        .any_req    (w_rr_any)
    );

    assign w_accept   = (r_state == XFER) && bus.req_valid[r_grant_id]
                        && (!r_noc_valid || bus.noc_ready);
    assign w_own_last = bus.req_last[r_grant_id];
    assign w_pkt_end  = w_own_last || (r_pkt_len == c_LEN_LAST);

    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[r_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= c_LAST_INIT;
            r_grant_id   <= '0;
            r_pkt_len    <= '0;
            r_busy       <= 1'b0;
            r_pkt_err    <= 1'b0;
            r_noc_data   <= '0;
            r_noc_valid  <= 1'b0;
            r_noc_last   <= 1'b0;
        end else begin
            // Output stage refills on accept, otherwise empties on handoff.
            if (w_accept) begin
                r_noc_data  <= w_req_word[r_grant_id];
                r_noc_last  <= w_pkt_end;
                r_noc_valid <= 1'b1;
                r_pkt_len   <= r_pkt_len + c_LEN_W'(1);
            end else if (bus.noc_ready) begin
                r_noc_valid <= 1'b0;
                r_noc_last  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_winner;
                        r_busy     <= 1'b1;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (w_accept && w_pkt_end) begin
                        r_last_grant <= r_grant_id;
                        if (!w_own_last) begin
                            r_pkt_err <= 1'b1;
                        end
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_noc_valid && bus.noc_ready) begin
                        r_busy    <= 1'b0;
                        r_pkt_len <= '0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.noc_data  = r_noc_data;
    assign bus.noc_valid = r_noc_valid;
    assign bus.noc_last  = r_noc_last;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = r_busy;
    assign bus.pkt_err   = r_pkt_err;

endmodule
`default_nettype wire

// File: doc/noc_tx_arbiter.md
Name: noc_tx_arbiter

Overview:
Shares the single 32-bit NoC output data channel between several packet sources: the Nios software path plus hardware accelerators. Arbitration is round-robin at packet granularity. Once a requester is granted, the grant is held until that requester's last word. Words are forwarded through a registered output stage with a valid/ready handshake toward the NoC.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, word width of the NoC data channel
MAX_PKT_WORDS, 16, packet length limit; the packet is force-terminated once this many words are sent without req_last
ID_W, $clog2(NUM_REQ), width of grant_id (derived, not overridden)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*DATA_W  per-requester word; requester i occupies bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  marks the final word of a packet
req_ready  out  NUM_REQ  per-requester word accepted this cycle (one-hot or zero)
noc_data  out  DATA_W  registered word to the NoC
noc_valid  out  1  noc_data valid
noc_ready  in  1  NoC accepts noc_data this cycle
noc_last  out  1  registered last flag accompanying noc_data
grant_id  out  ID_W  index of the current owner (valid while busy)
busy  out  1  a packet is in progress
pkt_err  out  1  sticky flag: a packet was truncated at MAX_PKT_WORDS

Behaviour:
- Reset: clk and reset_n; reset is asynchronous, active-low. All outputs are 0. State is IDLE. last_grant = NUM_REQ-1, so requester 0 wins first. pkt_len = 0.
- FSM states: IDLE, XFER, DRAIN.
- IDLE:
  - if any req_valid is set, pick the first set index scanning last_grant+1 upward, with wrap modulo NUM_REQ.
  - register it as grant_id, set busy=1, go to XFER. Arbitration takes 1 cycle; req_ready stays 0 in IDLE.
- XFER:
  - req_ready[grant_id] = req_valid[grant_id] & (~noc_valid | noc_ready). All other req_ready bits are 0.
  - On accept: noc_data <= req_data[grant_id], noc_last <= req_last[grant_id] | (pkt_len == MAX_PKT_WORDS-1), noc_valid <= 1, pkt_len += 1.
  - If the owner drops req_valid mid-packet, the grant is held, no word moves, and the other requesters keep waiting.
  - On accept of the last word (req_last, or the forced limit): last_grant <= grant_id, go to DRAIN.
  - A forced limit without req_last sets pkt_err=1. pkt_err clears only on reset.
- DRAIN:
  - wait until the final word leaves (noc_valid & noc_ready), then clear busy and pkt_len and go to IDLE.
  - If noc_ready is already high in the same cycle the last word is accepted into the stage, DRAIN lasts 1 cycle.
- Output stage:
  - noc_data/noc_last/noc_valid hold stable while noc_valid & ~noc_ready.
  - noc_valid drops the cycle after handoff unless a new word is accepted in the same cycle (full throughput: 1 word/cycle).
- Latency: req_valid seen in IDLE at cycle 0 -> req_ready at cycle 1 -> noc_valid at cycle 2. Minimum gap between packets is 2 idle NoC cycles (DRAIN + IDLE).
- A single active requester is re-granted after the gap. Requesters never starve: worst-case wait is NUM_REQ-1 packets.
- Reset asserted mid-packet: immediate return to the reset state. The partial packet is dropped, with no noc_last emitted.

Optional Feature:
NOC_TX_ARB_PRIO_EN
- Defined: requester 0 (Nios software path) has strict priority in IDLE. It is granted whenever its req_valid is set, regardless of last_grant. Remaining requesters rotate round-robin among themselves.
- Undefined: pure round-robin across all NUM_REQ requesters.

Decomposition:
- Package noc_tx_pkg holds: the state enum (IDLE/XFER/DRAIN), default DATA_W=32, default NUM_REQ=4, default MAX_PKT_WORDS=16.
- Sub-module rr_pick: combinational; inputs req vector and last_grant; outputs winner index and any_req. The PRIO_EN masking is applied outside it.

Test Plan:
- Single requester 1 sends 3 words (A,B,C, last on C) with noc_ready=1 -> noc_valid at cycles 2..4, noc_last only with C, grant_id=1, then busy falls.
- Requesters 0,1,2 all hold 2-word packets -> grant order 0,1,2,0. No interleaving of words across packets.
- noc_ready held low for 5 cycles mid-packet -> noc_data stable and req_ready=0 throughout; no word lost or duplicated.
- Requester 3 sends 20 words with no last -> 16th word carries noc_last=1, pkt_err=1, grant released. Remaining words arrive as a new packet after re-arbitration.
- reset_n pulsed low during word 2 of 4 -> all outputs 0 immediately; after release, requester 0 is granted first.
- With NOC_TX_ARB_PRIO_EN: requesters 0 and 2 continuously valid -> requester 0 granted every packet. Without the macro, grants alternate 0,2,0,2.
